// File: rtl/regset_arbiter.sv
// regset_arbiter: two-port round-robin arbiter and sequencer
// for the 8 x 4-bit register set.
module regset_arbiter #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req_a,
  input  logic          Req_b,
  input  logic          Wr_a,
  input  logic          Wr_b,
  input  logic [AW-1:0] Addr_a,
  input  logic [AW-1:0] Addr_b,
  input  logic [DW-1:0] Wdata_a,
  input  logic [DW-1:0] Wdata_b,
  output logic          Ack_a,
  output logic          Ack_b,
  output logic [DW-1:0] Rdata_a,
  output logic [DW-1:0] Rdata_b,
  output logic          Busy,
  output logic [AW-1:0] Rs_addr,
  output logic [DW-1:0] Rs_din,
  output logic          Rs_rw,
  input  logic [DW-1:0] Rs_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    READ,
    ACK
  } state_t;

  state_t        state_q;
  logic          ptr_q;
  logic          gnt_q;
  logic          wr_q;
  logic          ack_a_q;
  logic          ack_b_q;
  logic          busy_q;
  logic          rs_rw_q;
  logic [AW-1:0] rs_addr_q;
  logic [DW-1:0] rs_din_q;
  logic [DW-1:0] rdata_a_q;
  logic [DW-1:0] rdata_b_q;

  logic          any_req;
  logic          gnt_d;
  logic          wr_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_d;

  // Pick the winner: a lone requester, else the pointer (1 = B).
  always_comb begin
    any_req = Req_a | Req_b;
    gnt_d   = (Req_a & Req_b) ? ptr_q : Req_b;
    wr_d    = gnt_d ? Wr_b    : Wr_a;
    addr_d  = gnt_d ? Addr_b  : Addr_a;
    data_d  = gnt_d ? Wdata_b : Wdata_a;
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      rs_rw_q   <= 1'b0;
      rs_addr_q <= '0;
      rs_din_q  <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      rs_rw_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            gnt_q     <= gnt_d;
            wr_q      <= wr_d;
            rs_rw_q   <= wr_d;
            rs_addr_q <= addr_d;
            rs_din_q  <= data_d;
          end
        end
        ISSUE: begin
          if (wr_q) begin
            state_q <= ACK;
            ack_a_q <= ~gnt_q;
            ack_b_q <= gnt_q;
          end else begin
            state_q <= READ;
          end
        end
        READ: begin
          state_q <= ACK;
          ack_a_q <= ~gnt_q;
          ack_b_q <= gnt_q;
          if (gnt_q) begin
            rdata_b_q <= Rs_dout;
          end else begin
            rdata_a_q <= Rs_dout;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= ~gnt_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Ack_a   = ack_a_q;
  assign Ack_b   = ack_b_q;
  assign Rdata_a = rdata_a_q;
  assign Rdata_b = rdata_b_q;
  assign Busy    = busy_q;
  assign Rs_addr = rs_addr_q;
  assign Rs_din  = rs_din_q;
  assign Rs_rw   = rs_rw_q;

endmodule
